mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl : single-outstanding load/store controller for the data memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_en,
  output logic        mem_wea,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_din,
  output logic [1:0]  mem_bit_width,
  output logic        mem_sign_extend,
  input  logic [63:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

  state_t      state;
  logic        rq_we;
  logic [63:0] rq_addr;
  logic [63:0] rq_wdata;
  logic [1:0]  rq_width;
  logic        rq_signed;
  logic [1:0]  wait_cnt;
  logic [63:0] rdata_q;
  logic        fault_q;
  logic        ready_q;
  logic        valid_q;
  logic        en_q;
  logic        wea_q;

  // Fault if the access leaves the 20-bit space, including straddling its top.
  logic [3:0]  acc_bytes;
  logic [20:0] last_byte;
  logic        req_fault;

  assign acc_bytes = 4'd1 << req_width;
  assign last_byte = {1'b0, req_addr[19:0]} + {17'd0, acc_bytes} - 21'd1;
  assign req_fault = (|req_addr[63:20]) | last_byte[20];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rq_we     <= 1'b0;
      rq_addr   <= '0;
      rq_wdata  <= '0;
      rq_width  <= '0;
      rq_signed <= 1'b0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      en_q      <= 1'b0;
      wea_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rq_we     <= req_we;
            rq_addr   <= req_addr;
            rq_wdata  <= req_wdata;
            rq_width  <= req_width;
            rq_signed <= req_signed;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            fault_q   <= req_fault;
            if (req_fault) begin
              state   <= RESP;
              valid_q <= 1'b1;
            end else begin
              state   <= ISSUE;
              en_q    <= 1'b1;
              wea_q   <= req_we;
            end
          end
        end
        ISSUE: begin
          wea_q <= 1'b0;
          if (rq_we) begin
            state   <= RESP;
            en_q    <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            state    <= WAIT;
            wait_cnt <= CNT_INIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            rdata_q <= mem_dout;
            state   <= RESP;
            en_q    <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;

  // Reset gates the strobes immediately so an aborted store cannot write.
  assign mem_en  = en_q & ~rst;
  assign mem_wea = wea_q & ~rst;

  assign mem_addr        = rq_addr;
  assign mem_din         = rq_wdata;
  assign mem_bit_width   = rq_width;
  assign mem_sign_extend = rq_signed;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl : directed bench, two DUTs (latency 1 and 3) on byte memories
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [63:0] req_addr [2];
  logic [63:0] req_wdata [2];
  logic [1:0]  req_width [2];
  logic        req_signed [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [63:0] rsp_rdata [2];
  logic        rsp_fault [2];
  logic        mem_en [2];
  logic        mem_wea [2];
  logic [63:0] mem_addr [2];
  logic [63:0] mem_din [2];
  logic [1:0]  mem_bit_width [2];
  logic        mem_sign_extend [2];
  logic [63:0] mem_dout [2];

  logic [7:0]  mem [2][0:4095];
  int          en_run [2];
  int          lat_cfg [2];

  int n_checks = 0;
  int n_passed = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_width(req_width[0]),
    .req_signed(req_signed[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0]), .mem_en(mem_en[0]),
    .mem_wea(mem_wea[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]),
    .mem_bit_width(mem_bit_width[0]), .mem_sign_extend(mem_sign_extend[0]),
    .mem_dout(mem_dout[0])
  );

  mem_access_ctrl #(.MEM_LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_width(req_width[1]),
    .req_signed(req_signed[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1]), .mem_en(mem_en[1]),
    .mem_wea(mem_wea[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]),
    .mem_bit_width(mem_bit_width[1]), .mem_sign_extend(mem_sign_extend[1]),
    .mem_dout(mem_dout[1])
  );

  // Little-endian read with optional sign extension, as the memory unit does.
  function automatic logic [63:0] mem_read(input int d, input logic [11:0] a,
                                           input logic [1:0] w, input logic s);
    logic [63:0] v;
    int          n;
    logic [11:0] ai;
    v = '0;
    n = 1 << w;
    for (int k = 0; k < n; k++) begin
      ai = a + 12'(k);
      v[8*k +: 8] = mem[d][ai];
    end
    if (s && n < 8 && v[8*n-1])
      for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en[d] && mem_wea[d]) begin
        for (int k = 0; k < (1 << mem_bit_width[d]); k++)
          mem[d][mem_addr[d][11:0] + 12'(k)] = mem_din[d][8*k +: 8];
      end
      en_run[d] = mem_en[d] ? en_run[d] + 1 : 0;
    end
  end

  // Data only becomes valid MEM_LATENCY enabled cycles after mem_en rises.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (en_run[d] >= lat_cfg[d])
        mem_dout[d] = mem_read(d, mem_addr[d][11:0], mem_bit_width[d], mem_sign_extend[d]);
      else
        mem_dout[d] = 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_passed++;
  endtask

  task automatic xact(input int d, input logic we, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [1:0] width, input logic sgn,
                      input int hold, output logic [63:0] rdata, output logic fault,
                      output int lat, output int ens, output int weas);
    int guard;
    rdata = '0; fault = 1'b0; lat = 0; ens = 0; weas = 0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_width[d] = width; req_signed[d] = sgn;
    guard = 0;
    while (!req_ready[d] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready[d]) begin
      check("handshake_timeout", 64'd0, 64'd1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Junk on the request bus while busy must be ignored.
    req_valid[d] = 1'b0; req_we[d] = ~we; req_addr[d] = 64'hFFFF_0000_DEAD_BEEF;
    req_wdata[d] = 64'h5A5A_5A5A_5A5A_5A5A; req_width[d] = ~width; req_signed[d] = ~sgn;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (mem_en[d]) ens++;
      if (mem_wea[d]) weas++;
      if (rsp_valid[d]) break;
    end
    if (!rsp_valid[d]) begin
      check("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    rdata = rsp_rdata[d];
    fault = rsp_fault[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid[d]), 64'd1);
      check("hold_rsp_rdata", rsp_rdata[d], rdata);
      check("hold_req_ready", 64'(req_ready[d]), 64'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    check("post_accept_ready", 64'(req_ready[d] & ~rsp_valid[d]), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic        flt;
    int          lat, ens, weas;

    lat_cfg[0] = 1;
    lat_cfg[1] = 3;
    for (int d = 0; d < 2; d++) begin
      en_run[d] = 0;
      mem_dout[d] = '0;
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      req_width[d] = '0; req_signed[d] = 1'b0; rsp_ready[d] = 1'b0;
      for (int a = 0; a < 4096; a++) mem[d][a] = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready[0]), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check("rst_mem_en_wea", 64'({mem_en[0], mem_wea[0]}), 64'd0);
    check("rst_mem_addr", mem_addr[0], 64'd0);
    check("rst_mem_din", mem_din[0], 64'd0);
    check("rst_width_sign", 64'({mem_bit_width[0], mem_sign_extend[0]}), 64'd0);
    check("rst_rsp_data", rsp_rdata[0] | 64'(rsp_fault[0]), 64'd0);

    // Double store then load, latency 1.
    xact(0, 1'b1, 64'h10, 64'h1122_3344_5566_7788, 2'b11, 1'b0, 0, rd, flt, lat, ens, weas);
    check("st64_lat", 64'(lat), 64'd2);
    check("st64_en_wea", 64'({ens[3:0], weas[3:0]}), 64'h11);
    check("st64_rsp", {rd[62:0], flt}, 64'd0);
    xact(0, 1'b0, 64'h10, 64'h0, 2'b11, 1'b0, 0, rd, flt, lat, ens, weas);
    check("ld64_lat", 64'(lat), 64'd3);
    check("ld64_en_wea", 64'({ens[3:0], weas[3:0]}), 64'h20);
    check("ld64_data", rd, 64'h1122_3344_5566_7788);
    check("ld64_fault", 64'(flt), 64'd0);

    // Byte store, signed and unsigned reload.
    xact(0, 1'b1, 64'h23, 64'h80, 2'b00, 1'b0, 0, rd, flt, lat, ens, weas);
    check("st8_fault", 64'(flt), 64'd0);
    xact(0, 1'b0, 64'h23, 64'h0, 2'b00, 1'b1, 0, rd, flt, lat, ens, weas);
    check("ld8_signed", rd, 64'hFFFF_FFFF_FFFF_FF80);
    xact(0, 1'b0, 64'h23, 64'h0, 2'b00, 1'b0, 0, rd, flt, lat, ens, weas);
    check("ld8_unsigned", rd, 64'h80);

    // Range faults and the last legal byte.
    xact(0, 1'b0, 64'hFFFFE, 64'h0, 2'b10, 1'b0, 0, rd, flt, lat, ens, weas);
    check("flt_word_lat", 64'(lat), 64'd1);
    check("flt_word_fault", 64'(flt), 64'd1);
    check("flt_word_rdata", rd, 64'd0);
    check("flt_word_en", 64'(ens), 64'd0);
    xact(0, 1'b0, 64'hFFFFF, 64'h0, 2'b00, 1'b0, 0, rd, flt, lat, ens, weas);
    check("edge_byte_fault", 64'(flt), 64'd0);
    check("edge_byte_lat", 64'(lat), 64'd3);
    xact(0, 1'b0, 64'hFFFF8, 64'h0, 2'b11, 1'b0, 0, rd, flt, lat, ens, weas);
    check("edge_dword_fault", 64'(flt), 64'd0);
    xact(0, 1'b1, 64'h1_0000_0010, 64'h77, 2'b00, 1'b0, 0, rd, flt, lat, ens, weas);
    check("hi_addr_fault", 64'(flt), 64'd1);
    check("hi_addr_no_write", 64'({ens[3:0], weas[3:0]}), 64'd0);

    // Back-pressured response held for five cycles.
    xact(0, 1'b0, 64'h10, 64'h0, 2'b11, 1'b0, 5, rd, flt, lat, ens, weas);
    check("hold_data", rd, 64'h1122_3344_5566_7788);

    // Reset during the ISSUE cycle of a store must suppress the write.
    xact(0, 1'b1, 64'h40, 64'h55, 2'b00, 1'b0, 0, rd, flt, lat, ens, weas);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 64'h40;
    req_wdata[0] = 64'hAA; req_width[0] = 2'b00; req_signed[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("rst_issue_en_wea", 64'({mem_en[0], mem_wea[0]}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_abort_no_rsp", 64'(rsp_valid[0]), 64'd0);
    end
    check("rst_abort_ready", 64'(req_ready[0]), 64'd1);
    xact(0, 1'b0, 64'h40, 64'h0, 2'b00, 1'b0, 0, rd, flt, lat, ens, weas);
    check("rst_abort_contents", rd, 64'h55);

    // Latency-3 instance: issue cycle plus three wait cycles with mem_en high.
    xact(1, 1'b1, 64'h8, 64'h0123_4567_89AB_CDEF, 2'b11, 1'b0, 0, rd, flt, lat, ens, weas);
    check("l3_store_lat", 64'(lat), 64'd2);
    xact(1, 1'b0, 64'h8, 64'h0, 2'b11, 1'b0, 0, rd, flt, lat, ens, weas);
    check("l3_load_lat", 64'(lat), 64'd5);
    check("l3_load_en_cycles", 64'(ens), 64'd4);
    check("l3_load_data", rd, 64'h0123_4567_89AB_CDEF);
    check("l3_load_fault", 64'(flt), 64'd0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
